// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-ported register file with pending-bit scoreboard
//
// Purpose:
//   Parameterised register file with NUM_RD_PORTS combinational read ports
//   and NUM_WR_PORTS write ports. Each register carries a pending bit that a
//   producer sets on issue (sb_set_*) and a write clears on completion. When
//   two or more write ports hit the same writable register, the higher-index
//   port wins and wr_conflict pulses for one cycle.
//
// Ports:
//   clk          in   single clock, all state updates on the rising edge
//   rst          in   asynchronous active-low reset
//   wr_en        in   [NUM_WR_PORTS]               per-port write enable
//   wr_addr      in   [NUM_WR_PORTS*ADDRESS_WIDTH] packed, port 0 in LSBs
//   wr_data      in   [NUM_WR_PORTS*DATA_WIDTH]    packed, port 0 in LSBs
//   rd_addr      in   [NUM_RD_PORTS*ADDRESS_WIDTH] packed, port 0 in LSBs
//   rd_data      out  [NUM_RD_PORTS*DATA_WIDTH]    packed, port 0 in LSBs
//   sb_set_en    in   mark sb_set_addr pending
//   sb_set_addr  in   [ADDRESS_WIDTH]
//   rd_busy      out  [NUM_RD_PORTS] pending bit of each read port's register
//   wr_conflict  out  registered one-cycle pulse on a same-address dual write
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned NUM_REGS      = 32,
    parameter int unsigned NUM_RD_PORTS  = 2,
    parameter int unsigned NUM_WR_PORTS  = 2,
    parameter bit          ZERO_REG      = 1'b1,
    parameter bit          BYPASS        = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_WR_PORTS-1:0]               wr_en,
    input  logic [NUM_WR_PORTS*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]    wr_data,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_data,
    input  logic                                  sb_set_en,
    input  logic [ADDRESS_WIDTH-1:0]              sb_set_addr,
    output logic [NUM_RD_PORTS-1:0]               rd_busy,
    output logic                                  wr_conflict
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs_q    [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d    [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;
    logic                  wr_conflict_q;
    logic                  wr_conflict_d;

    // Unpacked views of the packed port buses
    logic [ADDRESS_WIDTH-1:0] wa    [NUM_WR_PORTS];
    logic [DATA_WIDTH-1:0]    wd    [NUM_WR_PORTS];
    logic [ADDRESS_WIDTH-1:0] ra    [NUM_RD_PORTS];
    logic [DATA_WIDTH-1:0]    rdat  [NUM_RD_PORTS];
    logic                     rbusy [NUM_RD_PORTS];

    // A register is writable when it is implemented and not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] a);
        addr_ok = (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    genvar g;
    generate
        for (g = 0; g < NUM_WR_PORTS; g++) begin : g_wr_unpack
            assign wa[g] = wr_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign wd[g] = wr_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
        for (g = 0; g < NUM_RD_PORTS; g++) begin : g_rd_pack
            assign ra[g]                          = rd_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = rdat[g];
            assign rd_busy[g]                     = rbusy[g];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state: storage and scoreboard
    // Ports are scanned in ascending order so the highest-index enabled port
    // is the last assignment and therefore wins. Within a register, the write
    // clear is applied before the sb_set so a simultaneous set survives.
    // -----------------------------------------------------------------------
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (!(ZERO_REG && (r == 0))) begin
                for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
                    if (wr_en[w] && (wa[w] == ADDRESS_WIDTH'(r))) begin
                        regs_d[r]    = wd[w];
                        pending_d[r] = 1'b0;
                    end
                end
                if (sb_set_en && (sb_set_addr == ADDRESS_WIDTH'(r))) begin
                    pending_d[r] = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Same-address dual-write detection, registered into a one-cycle pulse
    // -----------------------------------------------------------------------
    always_comb begin
        wr_conflict_d = 1'b0;
        for (int unsigned i = 0; i < NUM_WR_PORTS; i++) begin
            for (int unsigned j = i + 1; j < NUM_WR_PORTS; j++) begin
                if (wr_en[i] && wr_en[j] && (wa[i] == wa[j]) && addr_ok(wa[i])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pending_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pending_q     <= pending_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    // -----------------------------------------------------------------------
    // Read ports
    // Decode by comparison rather than indexing so out-of-range addresses
    // fall through to zero. Bypass is restricted to writable addresses, which
    // keeps register 0 and unimplemented addresses at zero. The output is
    // forced to zero while reset is held so a presented write cannot leak
    // through the bypass path.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            rdat[p]  = '0;
            rbusy[p] = 1'b0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (ra[p] == ADDRESS_WIDTH'(r)) begin
                    rdat[p]  = regs_q[r];
                    rbusy[p] = pending_q[r];
                end
            end
            if (BYPASS && addr_ok(ra[p])) begin
                for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
                    if (wr_en[w] && (wa[w] == ra[p])) begin
                        rdat[p] = wd[w];
                    end
                end
            end
            if (!rst) begin
                rdat[p]  = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

endmodule
